icache_responder: RTL

Instruction-side cache responder serving the fetch stage's instruction reads. Accepts one fetch address per cycle; on a hit it returns the 16-bit instruction in the same cycle; on a miss it raises `stall`, fills a 4-word line from backing memory through a ready handshake, then completes the request. It sits between the fetch stage (PC/instruction port) and the unified memory arbiter.

---
 rtl/icache_responder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/icache_responder.sv
// icache_responder
//   Direct-mapped, read-only instruction cache in front of the unified memory
//   arbiter. A hit returns the 16-bit instruction in the same cycle. A miss
//   raises o_stall, fills the 4-word line in order (word 0..3) through a
//   ready handshake, and then completes the request in a RESPOND cycle.
//
// Parameters
//   LINES          number of lines, power of two, 2..64
//
// Ports
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_req_valid     fetch request present (held stable while o_stall=1)
//   i_req_addr      instruction byte address, bit 0 ignored
//   i_flush         invalidate all lines on the next edge
//   o_instr         instruction word, valid when o_done=1
//   o_done          request completes this cycle
//   o_hit           completion was a hit
//   o_stall         request accepted but not yet complete
//   o_mem_rd        backing-memory word read request
//   o_mem_addr      backing-memory byte address
//   i_mem_data      backing-memory read data
//   i_mem_ready     read data valid / read accepted this cycle
//   o_hit_cnt, o_miss_cnt  saturating statistics (only with ICACHE_STATS_EN)
//
// Build option
//   ICACHE_STATS_EN  adds the hit/miss statistics counters and ports.
module icache_responder #(
    parameter int LINES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    input  logic [15:0] i_req_addr,
    input  logic        i_flush,
    output logic [15:0] o_instr,
    output logic        o_done,
    output logic        o_hit,
    output logic        o_stall,
    output logic        o_mem_rd,
    output logic [15:0] o_mem_addr,
    input  logic [15:0] i_mem_data,
    input  logic        i_mem_ready
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] o_hit_cnt,
    output logic [15:0] o_miss_cnt
`endif
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 13 - IW;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RESPOND} state_t;

    state_t            r_state;
    logic [LINES-1:0]  r_valid;
    logic [TW-1:0]     r_tag  [LINES];
    logic [15:0]       r_data [LINES][4];
    logic [TW-1:0]     r_mtag;
    logic [IW-1:0]     r_midx;
    logic [1:0]        r_moff;
    logic [1:0]        r_cnt;

    logic [1:0]        w_off;
    logic [IW-1:0]     w_idx;
    logic [TW-1:0]     w_tag;
    logic              w_tag_hit;
    logic              w_lookup_hit;
    logic              w_miss;
    logic              w_cap;
    logic              w_unused;

    assign w_off        = i_req_addr[2:1];
    assign w_idx        = i_req_addr[2+IW:3];
    assign w_tag        = i_req_addr[15:3+IW];
    assign w_tag_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_lookup_hit = (r_state == S_IDLE) && i_req_valid && w_tag_hit;
    assign w_miss       = (r_state == S_IDLE) && i_req_valid && !w_tag_hit;
    assign w_cap        = (r_state == S_FILL) && i_mem_ready;
    assign w_unused     = i_req_addr[0];

    // Control state. The install of the in-flight line is written after the
    // flush clear so a flush during FILL still leaves that line valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_cnt   <= '0;
            r_mtag  <= '0;
            r_midx  <= '0;
            r_moff  <= '0;
        end else begin
            if (i_flush)
                r_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_cnt   <= '0;
                        r_mtag  <= w_tag;
                        r_midx  <= w_idx;
                        r_moff  <= w_off;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (i_mem_ready) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_valid[r_midx] <= 1'b1;
                            r_state         <= S_RESPOND;
                        end
                    end
                end
                S_RESPOND: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Line storage needs no reset; r_valid alone qualifies it.
    always_ff @(posedge i_clk) begin
        if (w_cap) begin
            r_data[r_midx][r_cnt] <= i_mem_data;
            if (r_cnt == 2'd3)
                r_tag[r_midx] <= r_mtag;
        end
    end

    // Outputs are decoded from state so a hit answers in the request cycle.
    // Gating with reset makes a mid-fill reset drop them immediately even if
    // the requester is still presenting a request.
    always_comb begin
        o_instr    = '0;
        o_done     = 1'b0;
        o_hit      = 1'b0;
        o_stall    = 1'b0;
        o_mem_rd   = 1'b0;
        o_mem_addr = '0;
        if (i_rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        if (w_tag_hit) begin
                            o_done  = 1'b1;
                            o_hit   = 1'b1;
                            o_instr = r_data[w_idx][w_off];
                        end else begin
                            o_stall = 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    o_stall    = 1'b1;
                    o_mem_rd   = 1'b1;
                    o_mem_addr = {r_mtag, r_midx, r_cnt, 1'b0};
                end
                S_RESPOND: begin
                    o_done  = 1'b1;
                    o_instr = r_data[r_midx][r_moff];
                end
                default: ;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_lookup_hit && (r_hit_cnt != 16'hFFFF))
                r_hit_cnt <= r_hit_cnt + 16'd1;
            if (w_miss && (r_miss_cnt != 16'hFFFF))
                r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;
`endif

endmodule
